// File: rtl/mario_pixel_gen.sv
// mario_pixel_gen: per-pixel colour source for the VGA driver.
// Composites a 16x16 ROM sprite over a scrolling ground band over a flat sky.
// The colour for each request comes out one clk_vga later.
// Sprite and scroll changes are applied only at frame end.
//   clk_vga          : pixel clock
//   rst_n            : synchronous, active-low reset
//   x_i, y_i         : requested column and 1-based row (y_i == 0 means blanking)
//   pos_x_i, pos_y_i : host sprite position (left column, 0-based top row)
//   flip_h_i         : host horizontal mirror
//   pos_we_i         : strobe capturing the host values into the pending registers
//   scroll_step_i    : ground scroll increment applied at each frame end
//   rgb_o            : registered colour of the pixel requested on the previous cycle
//   frame_tick_o     : one-cycle pulse after row 480 has ended; the commit happens at its end
//   pend_o           : a host write is waiting for commit
// SPR_ROM packs the 256 x 4-bit sprite image, entry a at bits [a*4 +: 4].
// Bit 3 of an entry is opacity and bits 2:0 are its colour.
module mario_pixel_gen #(
    parameter logic [1023:0] SPR_ROM    = '0,
    parameter logic [9:0]    GROUND_Y   = 10'd416,
    parameter logic [2:0]    SKY_RGB    = 3'b011,
    parameter logic [2:0]    GROUND_RGB = 3'b100,
    parameter logic [2:0]    GROUND_ALT = 3'b110
) (
    input  logic       clk_vga,
    input  logic       rst_n,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic [9:0] pos_x_i,
    input  logic [8:0] pos_y_i,
    input  logic       flip_h_i,
    input  logic       pos_we_i,
    input  logic [3:0] scroll_step_i,
    output logic [2:0] rgb_o,
    output logic       frame_tick_o,
    output logic       pend_o
);
    logic [9:0] spr_x_q, scroll_q, last_y_q, pnd_x_q;
    logic [8:0] spr_y_q, pnd_y_q;
    logic       flip_q, pnd_f_q, pend_q, tick_q;
    logic [2:0] rgb_q, rgb_d;
    logic       tick_d;
    logic [9:0] row, dc, dr;
    logic [3:0] col, texel;
    logic       hit, alt;

    always_comb begin
        row    = y_i - 10'd1;
        // Unsigned wrap pushes pixels left of / above the sprite far past 16, so no wrap-around drawing
        dc     = x_i - spr_x_q;
        dr     = row - {1'b0, spr_y_q};
        hit    = (dc < 10'd16) && (dr < 10'd16);
        col    = flip_q ? 4'd15 - dc[3:0] : dc[3:0];
        texel  = SPR_ROM[{dr[3:0], col, 2'b00} +: 4];
        // Brick colour depends only on bit 4 of column + scroll, so the low five bits suffice
        alt    = |((x_i[4:0] + scroll_q[4:0]) & 5'h10);
        rgb_d  = (y_i == '0) ? 3'd0 :
                 (hit && texel[3]) ? texel[2:0] :
                 (row >= GROUND_Y) ? (alt ? GROUND_ALT : GROUND_RGB) : SKY_RGB;
        tick_d = (y_i == '0) && (last_y_q == 10'd480);
    end

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            rgb_q    <= '0;
            tick_q   <= 1'b0;
            last_y_q <= '0;
            scroll_q <= '0;
            spr_x_q  <= '0;
            spr_y_q  <= '0;
            flip_q   <= 1'b0;
            pnd_x_q  <= '0;
            pnd_y_q  <= '0;
            pnd_f_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            rgb_q  <= rgb_d;
            tick_q <= tick_d;
            // Clearing last_y on the pulse limits it to one per frame
            if (y_i != '0)
                last_y_q <= y_i;
            else if (tick_d)
                last_y_q <= '0;
            if (tick_q) begin
                scroll_q <= scroll_q + {6'd0, scroll_step_i};
                if (pend_q) begin
                    spr_x_q <= pnd_x_q;
                    spr_y_q <= pnd_y_q;
                    flip_q  <= pnd_f_q;
                end
            end
            // A write landing on the commit cycle stays pending for the next frame
            if (pos_we_i) begin
                pnd_x_q <= pos_x_i;
                pnd_y_q <= pos_y_i;
                pnd_f_q <= flip_h_i;
                pend_q  <= 1'b1;
            end else if (tick_q) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign rgb_o        = rgb_q;
    assign frame_tick_o = tick_q;
    assign pend_o       = pend_q;
endmodule

// File: tb/tb_mario_pixel_gen.sv
// tb_mario_pixel_gen: randomized and directed scoreboard bench for mario_pixel_gen.
module tb_mario_pixel_gen;
    function automatic logic [3:0] rom_val(input int a);
        logic op;
        op = (a % 16 != 10) && (a % 7 != 3);
        return {op, 3'((a * 5 + a / 16 + 1) % 8)};
    endfunction

    function automatic logic [1023:0] build_rom();
        logic [1023:0] v;
        for (int a = 0; a < 256; a++) v[a*4 +: 4] = rom_val(a);
        return v;
    endfunction

    localparam logic [1023:0] ROM_IMG = build_rom();

    typedef struct {
        logic [2:0] rgb;
        logic       tick;
        logic       pend;
        int         tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = '0, y = '0, pos_x = '0;
    logic [8:0] pos_y = '0;
    logic       flip = 1'b0, we = 1'b0;
    logic [3:0] st = '0;
    logic [2:0] rgb;
    logic       tick, pend;

    exp_t sb[$];
    int total = 0, bad = 0;
    int m_sx, m_sy, m_fl, m_sc, m_ly, m_pd, m_px, m_py, m_pf, m_tk;

    mario_pixel_gen #(.SPR_ROM(ROM_IMG)) dut (
        .clk_vga(clk), .rst_n(rst_n), .x_i(x), .y_i(y),
        .pos_x_i(pos_x), .pos_y_i(pos_y), .flip_h_i(flip), .pos_we_i(we),
        .scroll_step_i(st), .rgb_o(rgb), .frame_tick_o(tick), .pend_o(pend)
    );

    always #5 clk = ~clk;

    // Reference picture: sprite over ground over sky, straight from the layering rules
    function automatic int pix(input int c, input int yy);
        int r, dc, dr, col, t;
        if (yy == 0) return 0;
        r  = yy - 1;
        dc = (c - m_sx + 1024) % 1024;
        dr = (r - m_sy + 1024) % 1024;
        if (dc < 16 && dr < 16) begin
            col = m_fl != 0 ? 15 - dc : dc;
            t   = int'(rom_val(dr * 16 + col));
            if (t >= 8) return t - 8;
        end
        if (r >= 416) return ((((c + m_sc) % 1024) / 16) % 2 != 0) ? 6 : 4;
        return 3;
    endfunction

    task automatic cyc(input int xx, input int yy, input bit w, input int wx, input int wy,
                       input bit wf, input bit rs, input int want, input int tag);
        exp_t e;
        int nt;
        x = 10'(xx); y = 10'(yy); we = w; pos_x = 10'(wx); pos_y = 9'(wy); flip = wf; rst_n = rs;
        if (!rs) begin
            {m_sx, m_sy, m_fl, m_sc, m_ly, m_pd, m_px, m_py, m_pf, m_tk} = '0;
            e.rgb = 3'd0; e.tick = 1'b0; e.pend = 1'b0;
        end else begin
            e.rgb = 3'(want >= 0 ? want : pix(xx, yy));
            nt = (yy == 0 && m_ly == 480) ? 1 : 0;
            if (yy != 0) m_ly = yy;
            else if (nt != 0) m_ly = 0;
            if (m_tk != 0) begin
                m_sc = (m_sc + int'(st)) % 1024;
                if (m_pd != 0) begin
                    m_sx = m_px; m_sy = m_py; m_fl = m_pf; m_pd = 0;
                end
            end
            if (w) begin
                m_px = wx % 1024; m_py = wy % 512; m_pf = int'(wf); m_pd = 1;
            end
            m_tk = nt;
            e.tick = (nt != 0);
            e.pend = (m_pd != 0);
        end
        e.tag = tag;
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic req(input int xx, input int yy, input int want, input int tag);
        cyc(xx, yy, 1'b0, 0, 0, 1'b0, 1'b1, want, tag);
    endtask

    task automatic wr(input int wx, input int wy, input bit wf, input int tag);
        cyc(0, 0, 1'b1, wx, wy, wf, 1'b1, -1, tag);
    endtask

    task automatic rst_cyc(input int xx, input int yy, input int tag);
        cyc(xx, yy, 1'b0, 0, 0, 1'b0, 1'b0, -1, tag);
    endtask

    // Row 480, blanking, the tick cycle (optionally with a host write), more blanking
    task automatic fend(input bit w, input int wx, input int wy, input bit wf);
        req(0, 480, -1, 90);
        req(0, 0, -1, 91);
        cyc(0, 0, w, wx, wy, wf, 1'b1, -1, 92);
        req(0, 0, -1, 93);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total += 3;
            if (rgb !== e.rgb) begin
                bad++;
                $display("FAIL rgb tag=%0d got=%0d want=%0d t=%0t", e.tag, rgb, e.rgb, $time);
            end
            if (tick !== e.tick) begin
                bad++;
                $display("FAIL frame_tick tag=%0d got=%0b want=%0b t=%0t", e.tag, tick, e.tick, $time);
            end
            if (pend !== e.pend) begin
                bad++;
                $display("FAIL pend tag=%0d got=%0b want=%0b t=%0t", e.tag, pend, e.pend, $time);
            end
        end
    end

    initial begin
        rst_cyc(0, 0, 1);
        rst_cyc(0, 0, 2);
        req(0, 0, 0, 3);
        req(10, 1, 3, 4);
        // Pending write is invisible until frame end
        wr(100, 200, 1'b0, 10);
        req(100, 201, 3, 11);
        fend(1'b0, 0, 0, 1'b0);
        req(100, 201, int'(rom_val(0) & 4'h7), 12);
        // Mirrored sprite
        wr(100, 200, 1'b1, 20);
        fend(1'b0, 0, 0, 1'b0);
        req(100, 204, int'(rom_val(63) & 4'h7), 21);
        req(116, 204, 3, 22);
        // Ground scroll and its wrap
        rst_cyc(0, 0, 30);
        st = 4'd5;
        repeat (4) fend(1'b0, 0, 0, 1'b0);
        req(12, 417, 4, 31);
        req(0, 417, 6, 32);
        repeat (200) fend(1'b0, 0, 0, 1'b0);
        req(0, 417, 6, 33);
        fend(1'b0, 0, 0, 1'b0);
        req(15, 417, 6, 34);
        req(14, 417, 4, 35);
        st = 4'd0;
        // Host write landing on the tick cycle
        rst_cyc(0, 0, 40);
        wr(200, 50, 1'b0, 41);
        fend(1'b1, 300, 60, 1'b0);
        req(200, 51, int'(rom_val(0) & 4'h7), 42);
        fend(1'b0, 0, 0, 1'b0);
        req(300, 61, int'(rom_val(0) & 4'h7), 43);
        req(200, 51, 3, 44);
        // Right-edge clipping, then reset mid-row
        wr(630, 100, 1'b0, 50);
        fend(1'b0, 0, 0, 1'b0);
        for (int i = 630; i < 640; i++) req(i, 101, -1, 51);
        for (int i = 0; i < 6; i++) req(i, 101, 3, 52);
        rst_cyc(7, 101, 53);
        req(10, 1, 3, 54);
        req(0, 1, int'(rom_val(0) & 4'h7), 55);
        req(0, 0, -1, 56);
        // Randomized traffic, half of it aimed at the active sprite
        for (int i = 0; i < 3000; i++) begin
            int yy, xx;
            bit w, rs;
            if ($urandom % 2 == 0) begin
                xx = (m_sx + int'($urandom_range(0, 17))) % 1024;
                yy = m_sy + 1 + int'($urandom_range(0, 17));
                if (xx > 639) xx = 639;
                if (yy > 480) yy = 480;
            end else begin
                yy = ($urandom % 5 == 0) ? 0 : (($urandom % 20 == 0) ? 480 : int'($urandom_range(1, 480)));
                xx = int'($urandom_range(0, 639));
            end
            if ($urandom % 6 == 0) yy = 0;
            if (yy == 0) xx = 0;
            w  = ($urandom % 25 == 0);
            rs = ($urandom % 500 != 0);
            if ($urandom % 40 == 0) st = 4'($urandom);
            cyc(xx, yy, w, int'($urandom_range(0, 660)), int'($urandom_range(0, 490)),
                1'($urandom % 2), rs, -1, 100);
        end
        repeat (4) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mario_pixel_gen.md
Name: mario_pixel_gen

Overview:
- Per-pixel colour source feeding the VGA timing driver.
- Takes the driver's pixel-request coordinates and returns the 3-bit colour exactly one clk_vga later, which is the cycle in which the driver displays it.
- Composites three layers, highest priority first: a 16x16 player sprite from ROM, a scrolling ground band, and a flat sky.
- Sprite position, flip and scroll update only at frame boundaries, so the picture never tears.

Parameters:
- SPR_FILE, "mario_sprite.hex": 256-entry x 4-bit ROM image, row-major (addr = row*16+col). Bit3 = opaque; bits2:0 = colour.
- GROUND_Y, 10'd416: first visible row (0-based) of the ground band.
- SKY_RGB, 3'b011: sky colour.
- GROUND_RGB, 3'b100: ground brick colour A.
- GROUND_ALT, 3'b110: ground brick colour B.

Ports:
- clk_vga  in  1  pixel clock.
- rst_n  in  1  synchronous, active-low reset.
- x  in  10  pixel column 0..639; 0 outside the request window.
- y  in  10  1-based row (1 = top row, 480 = bottom); 0 means no request (blanking).
- pos_x  in  10  sprite left column, host side.
- pos_y  in  9  sprite top row, 0-based, host side.
- flip_h  in  1  mirror sprite horizontally, host side.
- pos_we  in  1  one-cycle strobe: capture pos_x/pos_y/flip_h into the pending registers.
- scroll_step  in  4  ground scroll increment per frame.
- rgb  out  3  colour for the requested pixel, registered.
- frame_tick  out  1  one-cycle pulse on the frame-end cycle (see Behaviour).
- pend  out  1  a host write is waiting for commit.

Behaviour:
- **Reset** (rst_n low at a clk_vga edge):
  - rgb = 0, frame_tick = 0, pend = 0.
  - Active sprite x/y = 0, active flip = 0, scroll = 0, last_y = 0.
  - Pending registers = 0.
- **Request**: visible when y != 0. Internal row r = y - 1 (0..479), column c = x.
- **Latency**: rgb at edge n+1 reflects the x/y sampled at edge n. The ROM is read asynchronously; there is exactly one register stage.
- **Blanking**: if y == 0, rgb <= 0 at the next edge.
- **Sprite hit**:
  - dc = c - spr_x and dr = r - spr_y, both 10-bit unsigned wrap.
  - Hit when dc < 16 and dr < 16.
  - col = flip ? 15 - dc : dc; ROM address = dr*16 + col.
  - Sprites at spr_x > 624 or spr_y > 464 are clipped naturally at the screen edge; they never wrap to the left or top.
- **Layer select**:
  - Sprite hit and ROM bit3 = 1: ROM bits2:0.
  - Otherwise, if r >= GROUND_Y: sum s = c + scroll (10-bit, mod 1024); colour = s[4] ? GROUND_ALT : GROUND_RGB.
  - Otherwise: SKY_RGB.
- **Frame end**:
  - last_y holds the most recent nonzero y.
  - frame_tick = 1 in the single cycle where y == 0 and last_y == 480. last_y is then cleared to 0, so the pulse is exactly one cycle per frame.
  - Row-to-row hblank gaps (y == 0, last_y < 480) do not pulse.
- **Host write**: on pos_we, pending <= {pos_x, pos_y, flip_h} and pend <= 1. A later write before commit overwrites the earlier one.
- **Commit** (registered, in the cycle frame_tick is high):
  - scroll <= scroll + scroll_step, mod 1024.
  - If pend = 1: active sprite regs <= pending and pend <= 0.
  - If pos_we coincides with the frame_tick cycle: the new values are captured into pending, pend stays/becomes 1, and they commit at the next frame end. The old pending value commits now.
- **Consistency**: active registers never change during visible rows.
- **Reset mid-frame**: all state is cleared. Rendering resumes with the next request using reset values. No frame_tick occurs until a full row-480 line has been seen.

Test Plan:
- Reset, then drive y = 0 and x = 0 -> rgb = 0, frame_tick = 0, pend = 0. After reset, request x = 10, y = 1 -> next cycle rgb = SKY_RGB (assumes ROM entry 10 is transparent; ROM addr 10 is only relevant because the reset sprite sits at 0,0).
- pos_we with pos_x = 100, pos_y = 200, flip = 0. Request (x = 100, y = 201) before frame end -> old layering, not sprite. Run to frame end -> frame_tick one cycle, pend 1->0. Request same pixel -> rgb = ROM[0][2:0] if bit3 set.
- flip_h = 1 committed: request dc = 0, dr = 3 -> colour of ROM addr 3*16+15. Request dc = 16 -> no hit.
- scroll_step = 5 over 4 frames -> scroll = 20. Request x = 12, y = 417 -> s = 32, s[4] = 0 -> GROUND_RGB. Request x = 0 -> s = 20, s[4] = 1 -> GROUND_ALT. Check scroll wrap 1020 + 5 = 1.
- pos_we asserted exactly in the frame_tick cycle -> pend stays 1; the value commits one frame later.
- Sprite at pos_x = 630: pixels x = 630..639 drawn; x = 0..5 of the same row show background (no wrap). Reset asserted mid-row -> rgb = 0 next cycle and sprite back at 0,0.
